tdm_nto1: RTL

Parametrised N:1 time-domain multiplexer for the fabric input port. It accepts wide flits on a valid/ready interface into a DEPTH-entry buffer and serialises each flit into RATIO narrow slices, MSB slice first. It runs in a single clock domain. Compared with the fixed 4:1 block, it adds:
- configurable ratio and buffer depth;
- bubble-free back-to-back serialisation;
- a slot index output;
- optional early termination of words with empty trailing slices.

---
 rtl/tdm_nto1.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/tdm_nto1.sv
// N:1 time-domain multiplexer: buffers wide flits in a small FIFO and serialises each one MSB slice first.
// Optional build macro TDM_SKIP_EMPTY_EN ends a word early once all of its remaining slices are empty.
module tdm_nto1 #(
  parameter int WIDTH_IN  = 64,
  parameter int RATIO     = 4,
  localparam int WIDTH_OUT = WIDTH_IN / RATIO,
  parameter int DEPTH     = 2,
  parameter int VALID_POS = WIDTH_OUT - 1,
  localparam int SLOT_W   = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH_IN-1:0]  i_data_in,
  input  logic                 i_valid_in,
  output logic                 i_ready_out,
  output logic [WIDTH_OUT-1:0] o_data_out,
  output logic                 o_valid_out,
  input  logic                 o_ready_in,
  output logic [SLOT_W-1:0]    o_slot_out,
  output logic                 o_first_out
);

  localparam int REM_W = WIDTH_IN - WIDTH_OUT;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  logic [WIDTH_IN-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  state_t               state_reg;
  logic [REM_W-1:0]     shift_reg;
  logic [WIDTH_OUT-1:0] data_reg;
  logic [SLOT_W-1:0]    slot_reg;
  logic                 valid_reg;
  logic                 first_reg;

  logic                 full;
  logic                 empty;
  logic                 wr_en;
  logic                 pop_en;
  logic                 last_slot;
  logic                 word_done;
  logic [WIDTH_IN-1:0]  head_word;

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  // Readiness comes from occupancy alone; a pop in the same cycle never frees a full buffer early.
  assign i_ready_out = rst_n & ~full;
  assign wr_en     = i_valid_in & i_ready_out;
  assign last_slot = (slot_reg == SLOT_W'(RATIO - 1));
  assign head_word = mem[rd_ptr_reg];

`ifdef TDM_SKIP_EMPTY_EN
  // shift_reg zero-fills from below, so slots past the end of the word read as empty.
  logic [RATIO-2:0] rem_valid;
  for (genvar gi = 0; gi < RATIO - 1; gi++) begin : g_rem_valid
    assign rem_valid[gi] = shift_reg[REM_W - (gi + 1) * WIDTH_OUT + VALID_POS];
  end
  assign word_done = last_slot | ~|rem_valid;
`else
  assign word_done = last_slot;
`endif

  assign pop_en = ~empty & ((state_reg == IDLE) |
                            ((state_reg == BUSY) & o_ready_in & word_done));

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (wr_en) begin
      wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
    end
    if (pop_en) begin
      rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
    end
    case ({wr_en, pop_en})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= i_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      state_reg  <= IDLE;
      shift_reg  <= '0;
      data_reg   <= '0;
      slot_reg   <= '0;
      valid_reg  <= 1'b0;
      first_reg  <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (pop_en) begin
        // Loading a new word also covers the last-slot handover, so back-to-back words have no bubble.
        state_reg <= BUSY;
        data_reg  <= head_word[WIDTH_IN-1 -: WIDTH_OUT];
        shift_reg <= head_word[REM_W-1:0];
        slot_reg  <= '0;
        valid_reg <= head_word[REM_W + VALID_POS];
        first_reg <= 1'b1;
      end else if ((state_reg == BUSY) && o_ready_in) begin
        if (word_done) begin
          state_reg <= IDLE;
          slot_reg  <= '0;
          valid_reg <= 1'b0;
          first_reg <= 1'b0;
        end else begin
          data_reg  <= shift_reg[REM_W-1 -: WIDTH_OUT];
          shift_reg <= shift_reg << WIDTH_OUT;
          slot_reg  <= slot_reg + SLOT_W'(1);
          valid_reg <= shift_reg[REM_W - WIDTH_OUT + VALID_POS];
          first_reg <= 1'b0;
        end
      end
    end
  end

  assign o_data_out  = data_reg;
  assign o_valid_out = valid_reg;
  assign o_slot_out  = slot_reg;
  assign o_first_out = first_reg;

endmodule
